fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-bus request per PC,
// holds the fetched word for decode, and reports address and bus-timeout errors.
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        pc_en,
  output logic        adel,
  output logic        ibe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'hFE;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        ibe_q, ibe_d;

  function automatic logic pc_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      adel_q  <= 1'b0;
      ibe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      adel_q  <= adel_d;
      ibe_q   <= ibe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    adel_d      = adel_q;
    ibe_d       = ibe_q;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    pc_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (pc_legal(pc)) begin
            imem_req  = 1'b1;
            imem_addr = pc;
            addr_d    = pc;
            cnt_d     = '0;
            state_d   = WAIT;
          end else begin
            instr_d = '0;
            adel_d  = 1'b1;
            ibe_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end

      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          if (!flush) begin
            instr_d = imem_rdata;
            adel_d  = 1'b0;
            ibe_d   = 1'b0;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Timeout: a flush in the same cycle voids the error slot as well.
          cnt_d = cnt_q + 8'd1;
          if (!flush) begin
            instr_d = '0;
            adel_d  = 1'b0;
            ibe_d   = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush) state_d = DROP;
        end
      end

      DROP: begin
        // Bus transaction is left to complete; its data is thrown away.
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
      end

      HOLD: begin
        if (!flush) begin
          instr_valid = 1'b1;
          if (!stall) begin
            pc_en   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign instr = instr_q;
  assign adel  = adel_q;
  assign ibe   = ibe_q;

endmodule
